cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM that sequences the CPU datapath through fetch, decode, execute, memory and writeback. It owns the program counter, instruction register, status flags and retired-instruction counter. It strobes the ROM, decoder, ALU, register bank and RAM, and evaluates each instruction's 2-bit condition field against the latched flags. It sits at CPU top level between the ROM/RAM/ALU/DECODER instances.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- MEM_TIMEOUT, 8'd15, maximum MEM-state cycles waiting for ram_ready before error
- HALT_WORD, 16'hFFFF, instruction encoding that halts the sequencer

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset
- run  in  1  level; 1 allows instruction issue from IDLE
- instr_in  in  16  ROM data for address rom_addr
- op_code  in  3  decoder field of ir_out, valid from DECODE onward
- condition  in  2  decoder field of ir_out, valid from DECODE onward
- negative, zero, overflow, carry  in  1 each  ALU flags, valid during EXECUTE
- ram_ready  in  1  RAM access complete (handshake)
- rom_addr  out  16  current PC
- rom_ce  out  1  ROM enable, FETCH only
- ir_out  out  16  instruction register to DECODER
- decode_en  out  1  DECODE strobe
- alu_en  out  1  EXECUTE strobe
- ram_ce  out  1  RAM request, held through MEM
- ram_rr  out  1  1 = read (load), 0 = write (store); valid while ram_ce
- reg_we  out  1  register-bank write, WRITEBACK only
- flags  out  4  latched {N,Z,V,C}
- retired  out  16  executed-instruction count, wraps
- state  out  3  current FSM state encoding
- halted  out  1  in HALT
- mem_err  out  1  sticky RAM timeout error

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
- IDLE:
  - run=1 goes to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - rom_ce=1, rom_addr=pc.
  - ir <= instr_in.
  - Go to DECODE.
- DECODE:
  - decode_en=1.
  - If ir==HALT_WORD, go to HALT; pc does not advance.
  - Otherwise evaluate the condition: 00 always; 01 zero flag; 10 negative flag; 11 carry flag. Use the latched flags, not the ALU inputs.
  - Condition false: instruction is skipped. pc <= pc+1, retired is unchanged, and the FSM goes to FETCH (IDLE if run=0).
  - Condition true: go to EXECUTE.
- EXECUTE:
  - alu_en=1.
  - flags <= {negative,zero,overflow,carry}.
  - op_code 110 (load) or 111 (store) goes to MEM; all others go to WRITEBACK.
- MEM:
  - ram_ce=1 on every MEM cycle; ram_rr = (op_code==110).
  - A timeout counter clears on MEM entry.
  - ram_ready=1 goes to WRITEBACK.
  - If the counter reaches MEM_TIMEOUT without ready: mem_err <= 1, go to HALT.
- WRITEBACK:
  - reg_we=1, except store (op 111), where reg_we=0.
  - pc <= pc+1; retired <= retired+1.
  - Go to FETCH if run=1, else IDLE.
- HALT: absorbing state; halted=1, all strobes 0. Only reset exits.
- pc arithmetic is 16-bit and wraps FFFF->0000. retired also wraps FFFF->0000.
- run is sampled only in IDLE, WRITEBACK and at the DECODE skip. Deasserting run mid-instruction completes the current instruction.
- All strobes are Moore outputs decoded from state; they are 0 in IDLE and HALT.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, ir=0, flags=0, retired=0.
  - halted=0, mem_err=0.
  - All strobes 0 (rom_ce, decode_en, alu_en, ram_ce, ram_rr, reg_we).
- reset=1 at any edge, including mid-MEM or in HALT, forces these values on that edge. Reset overrides all other inputs.
- Latency from FETCH entry to next FETCH entry:
  - ALU op: 4 cycles.
  - Load/store with ram_ready in the first MEM cycle: 5 cycles; each extra wait cycle adds 1.
  - Skipped instruction: 2 cycles.
- ram_ready is ignored outside MEM. ram_ready arriving on the same edge the timeout expires counts as success: ready wins.
- flags update only on the EXECUTE edge. A skipped instruction leaves flags unchanged.

## Test plan
- ALU instruction stream: reset, run=1, ROM at 0..2 holds cond=00 ALU ops -> state sequence 1,2,3,5 repeating; pc 0->1->2->3; retired=3 after 12 cycles of FETCH-entry-to-FETCH-entry; reg_we pulses once per 4 cycles.
- Conditional skip: flags Z=0, instruction cond=01 at pc 5 -> FETCH,DECODE only; alu_en never asserts; pc=6; retired unchanged; flags unchanged.
- Load with wait: op 110, ram_ready asserted on the 3rd MEM cycle -> ram_ce high for 3 cycles with ram_rr=1; reg_we=1 in WRITEBACK; total 7 cycles.
- Store timeout: op 111, ram_ready held 0 -> after MEM_TIMEOUT (15) MEM cycles, mem_err=1, halted=1, state=6; reg_we never asserts.
- Halt and wrap: RESET_PC=16'hFFFF, ALU op at FFFF, HALT_WORD at 0000 -> pc wraps to 0000; halted=1 with pc=0000; reset then restores pc=FFFF and halted=0, mem_err=0 in one cycle.
- Reset mid-MEM and run drop: assert reset during MEM -> next cycle state=0 and all outputs at reset values. Separately, drop run during EXECUTE -> instruction completes through WRITEBACK and the FSM then goes to IDLE.

Source files
------------

// File: rtl/cpu_seq_if.sv
// Bundle of ROM/RAM/ALU/decoder handshake signals between the CPU sequencer
// and the datapath blocks it strobes.
interface cpu_seq_if;
  logic        run;
  logic [15:0] instr_in;
  logic [2:0]  op_code;
  logic [1:0]  condition;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry;
  logic        ram_ready;
  logic [15:0] rom_addr;
  logic        rom_ce;
  logic [15:0] ir_out;
  logic        decode_en;
  logic        alu_en;
  logic        ram_ce;
  logic        ram_rr;
  logic        reg_we;
  logic [3:0]  flags;
  logic [15:0] retired;
  logic [2:0]  state;
  logic        halted;
  logic        mem_err;

  modport master (
    input  run, instr_in, op_code, condition, negative, zero, overflow, carry, ram_ready,
    output rom_addr, rom_ce, ir_out, decode_en, alu_en, ram_ce, ram_rr, reg_we,
           flags, retired, state, halted, mem_err
  );

  modport slave (
    output run, instr_in, op_code, condition, negative, zero, overflow, carry, ram_ready,
    input  rom_addr, rom_ce, ir_out, decode_en, alu_en, ram_ce, ram_rr, reg_we,
           flags, retired, state, halted, mem_err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM; owns pc, ir,
// flags and the retired-instruction counter.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd15,
  parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
  input  logic      clk,
  input  logic      reset,
  cpu_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;
  logic [3:0]  flags_reg, flags_next;
  logic [15:0] retired_reg, retired_next;
  logic [7:0]  tmo_reg, tmo_next;
  logic        err_reg, err_next;
  logic        cond_true;
  logic        is_mem_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      ir_reg      <= 16'h0000;
      flags_reg   <= 4'h0;
      retired_reg <= 16'h0000;
      tmo_reg     <= 8'd0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      flags_reg   <= flags_next;
      retired_reg <= retired_next;
      tmo_reg     <= tmo_next;
      err_reg     <= err_next;
    end
  end

  // flags are {N,Z,V,C}; the condition looks only at the latched copy
  always_comb begin
    cond_true = 1'b1;
    case (bus.condition)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = flags_reg[2];
      2'b10:   cond_true = flags_reg[3];
      default: cond_true = flags_reg[0];
    endcase
  end

  assign is_mem_op = (bus.op_code[2:1] == 2'b11);

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    flags_next   = flags_reg;
    retired_next = retired_reg;
    tmo_next     = tmo_reg;
    err_next     = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.run) state_next = S_FETCH;
      end
      S_FETCH: begin
        ir_next    = bus.instr_in;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (ir_reg == HALT_WORD) begin
          state_next = S_HALT;
        end else if (cond_true) begin
          state_next = S_EXECUTE;
        end else begin
          pc_next    = pc_reg + 16'd1;
          state_next = bus.run ? S_FETCH : S_IDLE;
        end
      end
      S_EXECUTE: begin
        flags_next = {bus.negative, bus.zero, bus.overflow, bus.carry};
        tmo_next   = 8'd0;
        state_next = is_mem_op ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        // ready is checked first so a reply on the final allowed cycle still succeeds
        if (bus.ram_ready) begin
          state_next = S_WRITEBACK;
        end else if (tmo_reg >= MEM_TIMEOUT - 8'd1) begin
          err_next   = 1'b1;
          state_next = S_HALT;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      S_WRITEBACK: begin
        pc_next      = pc_reg + 16'd1;
        retired_next = retired_reg + 16'd1;
        state_next   = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.rom_addr  = pc_reg;
  assign bus.ir_out    = ir_reg;
  assign bus.flags     = flags_reg;
  assign bus.retired   = retired_reg;
  assign bus.state     = state_reg;
  assign bus.mem_err   = err_reg;
  assign bus.halted    = (state_reg == S_HALT);
  assign bus.rom_ce    = (state_reg == S_FETCH);
  assign bus.decode_en = (state_reg == S_DECODE);
  assign bus.alu_en    = (state_reg == S_EXECUTE);
  assign bus.ram_ce    = (state_reg == S_MEM);
  assign bus.ram_rr    = (state_reg == S_MEM) && (bus.op_code == 3'b110);
  assign bus.reg_we    = (state_reg == S_WRITEBACK) && (bus.op_code != 3'b111);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level timeline model, per-cycle compare
// of every output, directed scenarios plus randomized streams.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       run_d = 1'b0;
  logic       rdy_d = 1'b0;
  logic [3:0] alu_d = 4'h0;
  logic       sel   = 1'b0;

  cpu_seq_if ifa ();
  cpu_seq_if ifb ();

  cpu_sequencer #(.RESET_PC(16'h0000)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  cpu_sequencer #(.RESET_PC(16'hFFFF)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

  logic [15:0] rom [0:65535];

  // ROM and decoder models feeding each DUT from its own outputs
  assign ifa.instr_in  = rom[ifa.rom_addr];
  assign ifa.op_code   = ifa.ir_out[15:13];
  assign ifa.condition = ifa.ir_out[12:11];
  assign ifa.run       = run_d;
  assign ifa.ram_ready = rdy_d;
  assign {ifa.negative, ifa.zero, ifa.overflow, ifa.carry} = alu_d;
  assign ifb.instr_in  = rom[ifb.rom_addr];
  assign ifb.op_code   = ifb.ir_out[15:13];
  assign ifb.condition = ifb.ir_out[12:11];
  assign ifb.run       = run_d;
  assign ifb.ram_ready = rdy_d;
  assign {ifb.negative, ifb.zero, ifb.overflow, ifb.carry} = alu_d;

  localparam int F_ST = 0, F_PC = 1, F_IR = 2, F_FL = 3, F_RET = 4, F_ERR = 5, F_HLT = 6;
  localparam int F_ROMCE = 7, F_DEC = 8, F_ALU = 9, F_RAMCE = 10, F_RR = 11, F_WE = 12;
  string fname [13] = '{"state", "pc", "ir", "flags", "retired", "mem_err", "halted",
                        "rom_ce", "decode_en", "alu_en", "ram_ce", "ram_rr", "reg_we"};

  logic [15:0] o [13];
  always_comb begin
    o[F_ST]    = {13'd0, sel ? ifb.state : ifa.state};
    o[F_PC]    = sel ? ifb.rom_addr : ifa.rom_addr;
    o[F_IR]    = sel ? ifb.ir_out : ifa.ir_out;
    o[F_FL]    = {12'd0, sel ? ifb.flags : ifa.flags};
    o[F_RET]   = sel ? ifb.retired : ifa.retired;
    o[F_ERR]   = {15'd0, sel ? ifb.mem_err : ifa.mem_err};
    o[F_HLT]   = {15'd0, sel ? ifb.halted : ifa.halted};
    o[F_ROMCE] = {15'd0, sel ? ifb.rom_ce : ifa.rom_ce};
    o[F_DEC]   = {15'd0, sel ? ifb.decode_en : ifa.decode_en};
    o[F_ALU]   = {15'd0, sel ? ifb.alu_en : ifa.alu_en};
    o[F_RAMCE] = {15'd0, sel ? ifb.ram_ce : ifa.ram_ce};
    o[F_RR]    = {15'd0, sel ? ifb.ram_rr : ifa.ram_rr};
    o[F_WE]    = {15'd0, sel ? ifb.reg_we : ifa.reg_we};
  end

  // stimulus per cycle and expected per-cycle timeline
  logic        run_a [0:511];
  logic        rdy_a [0:511];
  logic [3:0]  alu_a [0:511];
  logic [2:0]  e_st  [0:511];
  logic [15:0] e_pc  [0:511];
  logic [15:0] e_ir  [0:511];
  logic [3:0]  e_fl  [0:511];
  logic [15:0] e_ret [0:511];
  logic        e_err [0:511];

  typedef struct { int k; int f; logic [15:0] v; } lit_t;
  lit_t lits [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int scen  = 0;
  bit cmp_en = 1'b0;

  task automatic add_lit(input int k, input int f, input logic [15:0] v);
    lit_t l;
    l.k = k; l.f = f; l.v = v;
    lits.push_back(l);
  endtask

  task automatic rec(input int t, input int n, input logic [2:0] s, input logic [15:0] pc,
                     input logic [15:0] ir, input logic [3:0] fl, input logic [15:0] ret,
                     input logic err);
    if (t < n) begin
      e_st[t] = s; e_pc[t] = pc; e_ir[t] = ir; e_fl[t] = fl; e_ret[t] = ret; e_err[t] = err;
    end
  endtask

  // Walks the stimulus one instruction at a time and lays out its cycles.
  task automatic model(input logic [15:0] rpc, input int n);
    logic [15:0] pc, ir, ret;
    logic [3:0]  fl;
    logic        err, act, hlt, take, ok;
    int          t;
    pc = rpc; ir = 16'h0; ret = 16'h0; fl = 4'h0; err = 1'b0; act = 1'b0; hlt = 1'b0; t = 0;
    while (t < n) begin
      if (hlt) begin
        rec(t, n, 3'd6, pc, ir, fl, ret, err); t++;
      end else if (!act) begin
        rec(t, n, 3'd0, pc, ir, fl, ret, err); act = run_a[t]; t++;
      end else begin
        rec(t, n, 3'd1, pc, ir, fl, ret, err); ir = rom[pc]; t++;
        rec(t, n, 3'd2, pc, ir, fl, ret, err);
        case (ir[12:11])
          2'b00:   take = 1'b1;
          2'b01:   take = fl[2];
          2'b10:   take = fl[3];
          default: take = fl[0];
        endcase
        if (ir == 16'hFFFF) begin
          hlt = 1'b1; t++;
        end else if (!take) begin
          pc = pc + 16'd1; act = run_a[t]; t++;
        end else begin
          t++;
          rec(t, n, 3'd3, pc, ir, fl, ret, err); fl = alu_a[t]; t++;
          if (ir[15:14] == 2'b11) begin
            ok = 1'b0;
            for (int w = 0; w < 15; w++) begin
              rec(t, n, 3'd4, pc, ir, fl, ret, err);
              if (rdy_a[t]) begin ok = 1'b1; t++; break; end
              t++;
            end
            if (!ok) begin err = 1'b1; hlt = 1'b1; end
          end
          if (!hlt) begin
            rec(t, n, 3'd5, pc, ir, fl, ret, err);
            pc = pc + 16'd1; ret = ret + 16'd1; act = run_a[t]; t++;
          end
        end
      end
    end
    e_st[n] = 3'd0; e_pc[n] = rpc; e_ir[n] = 16'h0; e_fl[n] = 4'h0; e_ret[n] = 16'h0; e_err[n] = 1'b0;
  endtask

  function automatic logic [15:0] ev(input int f, input int k);
    logic [2:0] s;
    logic [2:0] op;
    s  = e_st[k];
    op = e_ir[k][15:13];
    case (f)
      F_ST:    return {13'd0, s};
      F_PC:    return e_pc[k];
      F_IR:    return e_ir[k];
      F_FL:    return {12'd0, e_fl[k]};
      F_RET:   return e_ret[k];
      F_ERR:   return {15'd0, e_err[k]};
      F_HLT:   return {15'd0, s == 3'd6};
      F_ROMCE: return {15'd0, s == 3'd1};
      F_DEC:   return {15'd0, s == 3'd2};
      F_ALU:   return {15'd0, s == 3'd3};
      F_RAMCE: return {15'd0, s == 3'd4};
      F_RR:    return {15'd0, (s == 3'd4) && (op == 3'b110)};
      F_WE:    return {15'd0, (s == 3'd5) && (op != 3'b111)};
      default: return 16'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s scen=%0d cyc=%0d got=%h want=%h", name, scen, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int f = 0; f < 13; f++) chk(fname[f], o[f], ev(f, cyc));
      foreach (lits[i]) if (lits[i].k == cyc) chk({"lit_", fname[lits[i].f]}, o[lits[i].f], lits[i].v);
    end
  end

  task automatic stim_default();
    for (int k = 0; k < 512; k++) begin
      run_a[k] = 1'b1; rdy_a[k] = 1'b0; alu_a[k] = 4'($urandom_range(0, 15));
    end
    for (int a = 0; a < 512; a++) rom[a] = 16'h0000;
    rom[16'hFFFF] = 16'h0000;
    lits.delete();
  endtask

  task automatic run_scen(input int id, input string name, input int n, input bit s);
    scen = id;
    sel  = s;
    model(s ? 16'hFFFF : 16'h0000, n);
    reset = 1'b1; run_d = 1'b0; rdy_d = 1'b0; alu_d = 4'h0;
    @(posedge clk); #1;
    for (int k = 0; k <= n; k++) begin
      cyc   = k;
      run_d = run_a[k]; rdy_d = rdy_a[k]; alu_d = alu_a[k];
      reset = (k == n - 1);
      cmp_en = 1'b1;
      @(posedge clk); #1;
    end
    cmp_en = 1'b0;
    $display("scenario %0d %s: %0d cycles, compared %0d, mismatched %0d", id, name, n, n_cmp, n_bad);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = 16'h0000;

    stim_default();
    rom[0] = 16'h0000; rom[1] = 16'h2000; rom[2] = 16'h4000;
    add_lit(0, F_ST, 0); add_lit(1, F_ST, 1); add_lit(2, F_ST, 2); add_lit(3, F_ST, 3);
    add_lit(4, F_ST, 5); add_lit(4, F_WE, 1); add_lit(5, F_WE, 0); add_lit(5, F_ST, 1);
    add_lit(13, F_PC, 3); add_lit(13, F_RET, 3); add_lit(16, F_PC, 0);
    run_scen(1, "alu_stream", 16, 1'b0);

    stim_default();
    rom[5] = 16'h0800;
    for (int k = 0; k < 512; k++) alu_a[k] = alu_a[k] & 4'b1011;
    add_lit(22, F_ST, 2); add_lit(23, F_ST, 1); add_lit(23, F_PC, 6); add_lit(23, F_RET, 5);
    add_lit(23, F_ALU, 0);
    run_scen(2, "cond_skip", 26, 1'b0);

    stim_default();
    rom[0] = 16'hC000;
    for (int k = 0; k < 4; k++) rdy_a[k] = 1'b1;
    rdy_a[6] = 1'b1;
    add_lit(4, F_RAMCE, 1); add_lit(6, F_RAMCE, 1); add_lit(6, F_RR, 1); add_lit(7, F_ST, 5);
    add_lit(7, F_WE, 1); add_lit(8, F_ST, 1); add_lit(8, F_PC, 1); add_lit(8, F_RET, 1);
    run_scen(3, "load_wait", 12, 1'b0);

    stim_default();
    rom[0] = 16'hE000;
    rdy_a[2] = 1'b1;
    add_lit(18, F_ST, 4); add_lit(18, F_ERR, 0); add_lit(19, F_ST, 6); add_lit(19, F_ERR, 1);
    add_lit(19, F_HLT, 1); add_lit(19, F_PC, 0); add_lit(19, F_RAMCE, 0);
    run_scen(4, "store_timeout", 24, 1'b0);

    stim_default();
    rom[16'hFFFF] = 16'h2000; rom[0] = 16'hFFFF;
    add_lit(1, F_PC, 16'hFFFF); add_lit(5, F_ST, 1); add_lit(5, F_PC, 0); add_lit(5, F_RET, 1);
    add_lit(7, F_ST, 6); add_lit(8, F_HLT, 1); add_lit(8, F_PC, 0);
    add_lit(10, F_PC, 16'hFFFF); add_lit(10, F_HLT, 0);
    run_scen(5, "halt_wrap", 10, 1'b1);

    stim_default();
    rom[0] = 16'hC000;
    alu_a[3] = 4'hF;
    add_lit(5, F_ST, 4); add_lit(5, F_FL, 4'hF); add_lit(6, F_ST, 0); add_lit(6, F_RAMCE, 0);
    add_lit(6, F_FL, 0);
    run_scen(6, "reset_mid_mem", 6, 1'b0);

    stim_default();
    for (int k = 3; k < 512; k++) run_a[k] = 1'b0;
    add_lit(3, F_ST, 3); add_lit(4, F_ST, 5); add_lit(5, F_ST, 0); add_lit(5, F_PC, 1);
    add_lit(5, F_RET, 1); add_lit(8, F_ST, 0);
    run_scen(7, "run_drop", 10, 1'b0);

    for (int r = 0; r < 3; r++) begin
      stim_default();
      for (int a = 0; a < 512; a++) begin
        rom[a] = 16'($urandom);
        if (rom[a] == 16'hFFFF) rom[a] = 16'h0000;
      end
      for (int k = 0; k < 512; k++) begin
        run_a[k] = ($urandom_range(0, 9) != 0);
        rdy_a[k] = (r == 2) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      end
      run_scen(8 + r, "random", 400, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
